// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: instruction prefetch FIFO between imem and decode, with
// redirect flush and in-flight response discard.
// Optional macro IF_PREFETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module if_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        stallF,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata
`ifdef IF_PREFETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_discarded
`endif
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = AW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]     DEPTH_S = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];

   logic [31:0] target;
   logic        fire, drop, push, pop;
   logic        unused_tgt_lsb;

   assign unused_tgt_lsb = ^PCTargetE[1:0];
   assign target         = {PCTargetE[31:2], 2'b00};

   // Handshake decode: request budget, response routing and consumer pop.
   always_comb begin
      imem_req   = rst_n && !PCSrcE && (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_S);
      imem_addr  = fetch_pc_q;
      fire       = imem_req && imem_gnt;
      drop       = imem_rvalid && (discard_q != '0);
      push       = imem_rvalid && (discard_q == '0) && !PCSrcE;
      inst_valid = count_q != '0;
      pop        = inst_valid && !stallF && !PCSrcE;
      inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
      inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
   end

   // Next-state: a redirect flushes the FIFO and turns every in-flight fetch into a discard.
   always_comb begin
      fetch_pc_d    = PCSrcE ? target : (fire ? fetch_pc_q + 32'd4 : fetch_pc_q);
      resp_pc_d     = PCSrcE ? target : (push ? resp_pc_q + 32'd4 : resp_pc_q);
      outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid);
      discard_d     = PCSrcE ? outstanding_q - CW'(imem_rvalid) : discard_q - CW'(drop);
      count_d       = PCSrcE ? '0 : count_q + CW'(push) - CW'(pop);
      wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d      = PCSrcE ? wr_ptr_q : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are masked at the output while empty, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
         fifo_inst_q[wr_ptr_q] <= imem_rdata;
      end
   end

`ifdef IF_PREFETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_discarded_q, perf_discarded_d;

   // Perf counters: accepted instructions, and dropped responses plus flushed entries.
   always_comb begin
      perf_fetched_d   = perf_fetched_q + 32'(push);
      perf_discarded_d = perf_discarded_q + 32'(drop)
                       + (PCSrcE ? 32'(count_q) + 32'(imem_rvalid && (discard_q == '0)) : 32'd0);
   end

   // Perf counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q   <= '0;
         perf_discarded_q <= '0;
      end else begin
         perf_fetched_q   <= perf_fetched_d;
         perf_discarded_q <= perf_discarded_d;
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_discarded = perf_discarded_q;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == DEPTH_C))
      else $error("prefetch FIFO push while full");

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: scoreboard bench; an in-order memory model answers
// rdata = addr ^ A5A5A5A5 and granted pcs are queued for comparison at pop.
module tb_if_prefetch_buffer;

   localparam logic [31:0] K        = 32'hA5A5_A5A5;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic        stallF = 1'b0;
   logic        inst_valid;
   logic [31:0] inst, inst_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
`ifdef IF_PREFETCH_PERF_EN
   logic [31:0] perf_fetched, perf_discarded;
`endif

   if_prefetch_buffer #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .PCSrcE(PCSrcE),
      .PCTargetE(PCTargetE),
      .stallF(stallF),
      .inst_valid(inst_valid),
      .inst(inst),
      .inst_pc(inst_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata)
`ifdef IF_PREFETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_discarded(perf_discarded)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          rdy;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] sb_q[$];
   logic [31:0] gpc;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          npop = 0;
   int          gmode = 0;
   int          dly = 1;
   int          rnd = 0;
   logic        stall_v = 1'b0;
   logic        redir_v = 1'b0;
   logic [31:0] tgt_v = '0;
   logic        s_valid, s_req;
   logic [31:0] s_addr, s_pc, s_inst, first_pc;

   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      if (pend_q.size() > 0 && pend_q[0].rdy <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend_q[0].addr ^ K;
         void'(pend_q.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      imem_gnt = (gmode == 2) ? 1'($urandom_range(0, 1)) : (gmode == 1);
      if (rnd != 0) begin
         stall_v = ($urandom_range(0, 3) == 0);
         redir_v = ($urandom_range(0, 39) == 0);
         tgt_v   = $urandom;
      end
      stallF    = stall_v;
      PCSrcE    = redir_v;
      PCTargetE = tgt_v;
      #1;
      s_valid = inst_valid;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_pc    = inst_pc;
      s_inst  = inst;
      if (PCSrcE) begin
         sb_q.delete();
         gpc = {PCTargetE[31:2], 2'b00};
      end
      if (s_valid && !stallF && !PCSrcE) begin
         if (npop == 0) first_pc = s_pc;
         npop++;
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected cyc=%0d inst_pc=%h required no instruction", cyc, s_pc);
         end else begin
            e = sb_q.pop_front();
            if (s_pc !== e || s_inst !== (e ^ K)) begin
               bad++;
               $display("FAIL pop_data cyc=%0d got pc=%h inst=%h required pc=%h inst=%h", cyc, s_pc, s_inst, e, e ^ K);
            end
         end
      end
      if (s_req && imem_gnt) begin
         total++;
         if (s_addr !== gpc) begin
            bad++;
            $display("FAIL fetch_addr cyc=%0d got %h required %h", cyc, s_addr, gpc);
         end
         pend_q.push_back('{s_addr, cyc + ((dly == 0) ? int'($urandom_range(1, 4)) : dly)});
         sb_q.push_back(gpc);
         gpc = gpc + 32'd4;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      PCSrcE      = 1'b0;
      stallF      = 1'b0;
      stall_v     = 1'b0;
      redir_v     = 1'b0;
      rnd         = 0;
      pend_q.delete();
      sb_q.delete();
      gpc = RESET_PC;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total += 4;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b required 0", inst_valid); end
      if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b required 0", imem_req); end
      if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got %h required 0", inst); end
      if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got %h required 0", inst_pc); end
      @(negedge clk);
      rst_n = 1'b1;
      gpc   = RESET_PC;
      #1;
      total += 2;
      if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got %b required 1", imem_req); end
      if (imem_addr !== RESET_PC) begin bad++; $display("FAIL first_addr got %h required %h", imem_addr, RESET_PC); end
   endtask

   task automatic test_stream();
      do_reset();
      gmode = 1; dly = 1; stall_v = 1'b0; redir_v = 1'b0;
      npop = 0;
      step();
      total += 2;
      if (s_req !== 1'b1) begin bad++; $display("FAIL stream_req0 got %b required 1", s_req); end
      if (s_valid !== 1'b0) begin bad++; $display("FAIL stream_valid0 got %b required 0", s_valid); end
      step();
      total++;
      if (s_valid !== 1'b0) begin bad++; $display("FAIL stream_valid1 got %b required 0", s_valid); end
      step();
      total += 2;
      if (s_valid !== 1'b1) begin bad++; $display("FAIL stream_valid2 got %b required 1", s_valid); end
      if (s_pc !== RESET_PC) begin bad++; $display("FAIL stream_first_pc got %h required %h", s_pc, RESET_PC); end
      npop = 0;
      repeat (16) step();
      total++;
      if (npop != 16) begin bad++; $display("FAIL stream_throughput got %0d pops required 16", npop); end
   endtask

   task automatic test_stall();
      do_reset();
      gmode = 1; dly = 1; stall_v = 1'b1; redir_v = 1'b0;
      npop = 0;
      repeat (10) step();
      total += 4;
      if (s_req !== 1'b0) begin bad++; $display("FAIL stall_req got %b required 0", s_req); end
      if (s_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got %b required 1", s_valid); end
      if (s_pc !== 32'h0) begin bad++; $display("FAIL stall_head_pc got %h required 0", s_pc); end
      if (npop != 0) begin bad++; $display("FAIL stall_pops got %0d required 0", npop); end
      stall_v = 1'b0;
      npop = 0;
      repeat (5) step();
      total += 2;
      if (npop != 5) begin bad++; $display("FAIL stall_release_pops got %0d required 5", npop); end
      if (s_pc !== 32'h10) begin bad++; $display("FAIL stall_release_last got %h required 10", s_pc); end
   endtask

   task automatic test_redirect();
      do_reset();
      gmode = 1; dly = 4; stall_v = 1'b0; redir_v = 1'b0;
      repeat (3) step();
      redir_v = 1'b1; tgt_v = 32'h0000_0103;
      step();
      total += 2;
      if (s_req !== 1'b0) begin bad++; $display("FAIL redirect_req got %b required 0", s_req); end
      if (pend_q.size() != 3) begin bad++; $display("FAIL redirect_inflight got %0d required 3", pend_q.size()); end
      redir_v = 1'b0; dly = 1;
      npop = 0;
      step();
      total += 2;
      if (s_req !== 1'b1) begin bad++; $display("FAIL redirect_next_req got %b required 1", s_req); end
      if (s_addr !== 32'h100) begin bad++; $display("FAIL redirect_next_addr got %h required 100", s_addr); end
      repeat (12) step();
      total += 2;
      if (npop < 4) begin bad++; $display("FAIL redirect_pops got %0d required >=4", npop); end
      if (first_pc !== 32'h100) begin bad++; $display("FAIL redirect_first_pc got %h required 100", first_pc); end
   endtask

   task automatic test_back_to_back();
      gmode = 1; dly = 2; stall_v = 1'b0; redir_v = 1'b0;
      repeat (4) step();
      redir_v = 1'b1; tgt_v = 32'h200;
      step();
      tgt_v = 32'h300;
      step();
      redir_v = 1'b0;
      npop = 0;
      step();
      total++;
      if (s_addr !== 32'h300) begin bad++; $display("FAIL b2b_next_addr got %h required 300", s_addr); end
      repeat (20) step();
      total += 2;
      if (first_pc !== 32'h300) begin bad++; $display("FAIL b2b_first_pc got %h required 300", first_pc); end
      if (npop < 10) begin bad++; $display("FAIL b2b_pops got %0d required >=10", npop); end
   endtask

   task automatic test_random();
      do_reset();
      gmode = 0; dly = 0; stall_v = 1'b0; redir_v = 1'b0;
      repeat (5) step();
      total += 2;
      if (s_req !== 1'b1) begin bad++; $display("FAIL nognt_req got %b required 1", s_req); end
      if (s_valid !== 1'b0) begin bad++; $display("FAIL nognt_valid got %b required 0", s_valid); end
      gmode = 2; rnd = 1;
      npop = 0;
      repeat (400) step();
      rnd = 0; stall_v = 1'b0; redir_v = 1'b0; gmode = 1;
      repeat (20) step();
      total++;
      if (npop < 60) begin bad++; $display("FAIL random_pops got %0d required >=60", npop); end
   endtask

   task automatic test_reset_mid();
      gmode = 1; dly = 1; stall_v = 1'b0; redir_v = 1'b0; rnd = 0;
      repeat (6) step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total += 4;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b required 0", inst_valid); end
      if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got %b required 0", imem_req); end
      if (inst !== 32'h0) begin bad++; $display("FAIL midrst_inst got %h required 0", inst); end
      if (inst_pc !== 32'h0) begin bad++; $display("FAIL midrst_inst_pc got %h required 0", inst_pc); end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; PCSrcE = 1'b0; stallF = 1'b0;
      pend_q.delete();
      sb_q.delete();
      gpc = RESET_PC;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total += 2;
      if (imem_req !== 1'b1) begin bad++; $display("FAIL midrst_next_req got %b required 1", imem_req); end
      if (imem_addr !== RESET_PC) begin bad++; $display("FAIL midrst_next_addr got %h required %h", imem_addr, RESET_PC); end
      npop = 0;
      repeat (8) step();
      total++;
      if (first_pc !== RESET_PC) begin bad++; $display("FAIL midrst_first_pc got %h required %h", first_pc, RESET_PC); end
   endtask

   initial begin
      gpc = RESET_PC;
      first_pc = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
